// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared constants and helpers for the iterative divider
package divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits needed to count 0 .. v-1.
    function automatic int clog2(input int v);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one restoring-division iteration (combinational)
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH:0]   divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor <= 2^(WIDTH-1), so the shifted value fits WIDTH+1 bits
    // and the kept remainder always fits back into WIDTH bits.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - divisor;
        q_bit   = (shifted >= divisor);
        rem_out = WIDTH'(q_bit ? diff : shifted);
    end

endmodule

// File: rtl/divider_32b.sv
// rtl/divider_32b.sv - iterative signed restoring divider, truncate-toward-zero
module divider_32b
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] x_lat;
    logic [WIDTH-1:0] y_lat;
    logic             x_neg;
    logic             y_neg;
    logic [WIDTH:0]   dvd;
    logic [WIDTH:0]   dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] rem_nx;
    logic             q_bit;
    logic [WIDTH:0]   x_abs;
    logic [WIDTH:0]   y_abs;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             dbz_fix;
    logic             ovf_fix;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in      (rem),
        .dividend_bit(dvd[WIDTH-1]),
        .divisor     (dsr),
        .rem_out     (rem_nx),
        .q_bit       (q_bit)
    );

    // Magnitudes carry an extra bit so that |-2^(WIDTH-1)| is representable.
    always_comb begin
        x_abs = x[WIDTH-1] ? ((WIDTH+1)'(0) - {1'b1, x}) : {1'b0, x};
        y_abs = y[WIDTH-1] ? ((WIDTH+1)'(0) - {1'b1, y}) : {1'b0, y};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = ST_FIX;
            end
            ST_FIX: begin
                busy     = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Sign correction; divide-by-zero wins over the single overflow pair.
    always_comb begin
        q_fix   = (x_neg ^ y_neg) ? (WIDTH'(0) - quo) : quo;
        r_fix   = x_neg ? (WIDTH'(0) - rem) : rem;
        dbz_fix = 1'b0;
        ovf_fix = 1'b0;
        if (y_lat == '0) begin
            q_fix   = '1;
            r_fix   = x_lat;
            dbz_fix = 1'b1;
        end else if (x_lat == {1'b1, {(WIDTH-1){1'b0}}} && y_lat == '1) begin
            q_fix   = x_lat;
            r_fix   = '0;
            ovf_fix = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_lat <= '0;
            y_lat <= '0;
            x_neg <= 1'b0;
            y_neg <= 1'b0;
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_lat <= x;
                        y_lat <= y;
                        x_neg <= x[WIDTH-1];
                        y_neg <= y[WIDTH-1];
                        dvd   <= x_abs;
                        dsr   <= y_abs;
                        rem   <= '0;
                        quo   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                    end
                end
                ST_CALC: begin
                    rem <= rem_nx;
                    quo <= {quo[WIDTH-2:0], q_bit};
                    dvd <= dvd << 1;
                    cnt <= cnt - 1'b1;
                end
                ST_FIX: begin
                    q   <= q_fix;
                    r   <= r_fix;
                    dbz <= dbz_fix;
                    ovf <= ovf_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32b.sv
// tb/tb_divider_32b.sv - self-checking bench for divider_32b
module tb_divider_32b;

    localparam int W = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic          busy;
    logic          done;
    logic          dbz;
    logic          ovf;

    int n_vec = 0;
    int n_err = 0;

    divider_32b #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .y    (y),
        .q    (q),
        .r    (r),
        .busy (busy),
        .done (done),
        .dbz  (dbz),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: C-style signed division plus the two special-case rules.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eq, output logic [31:0] er,
                           output logic ed, output logic eo);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        ed = 1'b0;
        eo = 1'b0;
        if (sb == 0) begin
            eq = 32'hFFFF_FFFF;
            er = a;
            ed = 1'b1;
        end else if (a == 32'h8000_0000 && sb == -1) begin
            eq = a;
            er = '0;
            eo = 1'b1;
        end else begin
            eq = sa / sb;
            er = sa % sb;
        end
    endtask

    // Issue one operation; optionally check per-cycle busy/latency and inject a stray start.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit timing, input int inject);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ed;
        logic        eo;
        logic [31:0] q_prev;
        bit          got;
        string       tag;
        tag = $sformatf("%0d/%0d", $signed(a), $signed(b));
        ref_div(a, b, eq, er, ed, eo);
        @(negedge clk);
        q_prev = q;
        x = a;
        y = b;
        start = 1'b1;
        got = 1'b0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                if (timing) chk({tag, " hold"}, q, q_prev);
            end
            if (inject > 0 && i == inject) begin
                start = 1'b1;
                x = 32'd9;
                y = 32'd3;
            end
            if (inject > 0 && i == inject + 1) start = 1'b0;
            if (done) begin
                got = 1'b1;
                if (timing) begin
                    chk({tag, " latency"}, i, LAT);
                    chk({tag, " busy@done"}, busy, 1'b0);
                end
            end else if (timing) begin
                chk($sformatf("%s busy@%0d", tag, i), busy, 1'b1);
            end
        end
        if (!got) begin
            chk({tag, " timeout"}, 1'b0, 1'b1);
        end else begin
            chk({tag, " q"}, q, eq);
            chk({tag, " r"}, r, er);
            chk({tag, " dbz"}, dbz, ed);
            chk({tag, " ovf"}, ovf, eo);
            if (!ed && !eo)
                chk({tag, " identity"},
                    64'(longint'($signed(q)) * longint'($signed(b)) + longint'($signed(r))),
                    64'(longint'($signed(a))));
        end
    endtask

    initial begin
        int          dn_cnt;
        int          first_done;
        int          second_done;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        #12;
        chk("reset q", q, 0);
        chk("reset r", r, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dbz", dbz, 0);
        chk("reset ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;

        // Basic operation with latency and busy window
        run_op(32'd100, 32'd7, 1'b1, 0);
        chk("100/7 q const", q, 14);
        chk("100/7 r const", r, 2);
        repeat (3) @(negedge clk);
        chk("hold q after done", q, 14);
        chk("done one pulse", done, 0);

        // Sign combinations
        run_op(-32'sd100, 32'd7, 1'b1, 0);
        chk("-100/7 q const", q, 32'hFFFF_FFF2);
        run_op(32'd100, -32'sd7, 1'b1, 0);
        run_op(-32'sd100, -32'sd7, 1'b1, 0);
        run_op(32'd7, -32'sd100, 1'b1, 0);

        // Special cases
        run_op(32'd5, 32'd0, 1'b1, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        chk("ovf q const", q, 32'h8000_0000);
        run_op(32'h8000_0000, 32'd1, 1'b1, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 0);

        // Stray start during a run is ignored and produces no second result
        run_op(32'd100, 32'd7, 1'b1, 10);
        dn_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) dn_cnt++;
        end
        chk("stray start extra done", dn_cnt, 0);
        chk("stray start q", q, 14);

        // start held high: back-to-back results
        @(negedge clk);
        x = 32'd100;
        y = 32'd7;
        start = 1'b1;
        first_done = 0;
        second_done = 0;
        for (int i = 1; i <= 120 && second_done == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (first_done == 0) first_done = i;
                else begin
                    second_done = i;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("held first done", first_done, LAT);
        chk("held period", second_done - first_done, W + 3);
        chk("held q", q, 14);

        // Asynchronous reset mid-run
        @(negedge clk);
        x = 32'd1000;
        y = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (14) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async q", q, 0);
        chk("async r", r, 0);
        chk("async busy", busy, 0);
        chk("async done", done, 0);
        chk("async dbz", dbz, 0);
        chk("async ovf", ovf, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        dn_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dn_cnt++;
        end
        chk("aborted op done", dn_cnt, 0);
        run_op(32'd42, 32'd6, 1'b1, 0);
        chk("42/6 q const", q, 7);

        // Randomized operands against the reference model
        for (int n = 0; n < 400; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 30)) - 32'd15;
                1:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            if (rb == 0) rb = 32'd1;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
            run_op(ra, rb, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
